// File: rtl/char_plane_scroll.sv
// Character plane with a registered read port, a random-access write port, a cursor-driven put port,
// hardware row-offset scroll and a clear sequencer. Optional macro: CHAR_PLANE_NEWLINE_EN (LF/CR handling on put).
module char_plane_scroll #(
    parameter int                 ROWS       = 16,
    parameter int                 COLS       = 32,
    parameter int                 ROW_W      = 4,
    parameter int                 COL_W      = 5,
    parameter int                 CHAR_W     = 8,
    parameter logic [CHAR_W-1:0]  BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [CHAR_W-1:0] rd_char,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              put_en,
    input  logic [CHAR_W-1:0] put_char,
    input  logic              clear_req,
    output logic              busy,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col
);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCROLL} state_t;

    state_t state_q, state_d;

    logic [CHAR_W-1:0] mem_q [ROWS][COLS];

    logic [CHAR_W-1:0] rd_char_q, rd_char_d;
    logic [ROW_W-1:0]  cur_row_q, cur_row_d;
    logic [COL_W-1:0]  cur_col_q, cur_col_d;
    logic [ROW_W-1:0]  offset_q, offset_d;
    logic [ROW_W-1:0]  seq_row_q, seq_row_d;
    logic [COL_W-1:0]  seq_col_q, seq_col_d;

    logic              mem_we;
    logic [ROW_W-1:0]  mem_row;
    logic [COL_W-1:0]  mem_col;
    logic [CHAR_W-1:0] mem_wdata;

    logic seq_last_row, seq_last_col, cur_last_row, cur_last_col;
    logic put_nl, put_cr, put_wraps, put_scroll, wr_ok, rd_ok;

    // Logical-to-physical row: ROWS need not be a power of two, so wrap by compare-and-subtract.
    function automatic logic [ROW_W-1:0] map_row(input logic [ROW_W-1:0] lrow,
                                                 input logic [ROW_W-1:0] off);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, off};
        if (sum >= (ROW_W+1)'(ROWS))
            sum = sum - (ROW_W+1)'(ROWS);
        return sum[ROW_W-1:0];
    endfunction

    assign seq_last_row = (seq_row_q == ROW_W'(ROWS-1));
    assign seq_last_col = (seq_col_q == COL_W'(COLS-1));
    assign cur_last_row = (cur_row_q == ROW_W'(ROWS-1));
    assign cur_last_col = (cur_col_q == COL_W'(COLS-1));

`ifdef CHAR_PLANE_NEWLINE_EN
    assign put_nl = (put_char == CHAR_W'(8'h0A));
    assign put_cr = (put_char == CHAR_W'(8'h0D));
`else
    assign put_nl = 1'b0;
    assign put_cr = 1'b0;
`endif

    // A put leaves the current line either by running off its end or by a newline.
    assign put_wraps  = put_nl || (cur_last_col && !put_cr);
    assign put_scroll = put_wraps && cur_last_row;

    assign wr_ok = ({1'b0, wr_row} < (ROW_W+1)'(ROWS)) && ({1'b0, wr_col} < (COL_W+1)'(COLS));
    assign rd_ok = ({1'b0, rd_row} < (ROW_W+1)'(ROWS)) && ({1'b0, rd_col} < (COL_W+1)'(COLS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR:  if (seq_last_row && seq_last_col) state_d = S_IDLE;
            S_IDLE: begin
                if (clear_req)                         state_d = S_CLEAR;
                else if (!wr_en && put_en && put_scroll) state_d = S_SCROLL;
            end
            S_SCROLL: if (seq_last_col) state_d = S_IDLE;
            default:  state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        mem_we    = 1'b0;
        mem_row   = seq_row_q;
        mem_col   = seq_col_q;
        mem_wdata = BLANK_CHAR;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        offset_d  = offset_q;
        seq_row_d = seq_row_q;
        seq_col_d = seq_col_q;
        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (seq_last_col) begin
                    seq_col_d = '0;
                    seq_row_d = seq_row_q + 1'b1;
                    if (seq_last_row) begin
                        seq_row_d = '0;
                        offset_d  = '0;
                        cur_row_d = '0;
                        cur_col_d = '0;
                    end
                end else begin
                    seq_col_d = seq_col_q + 1'b1;
                end
            end
            S_SCROLL: begin
                mem_we    = 1'b1;
                seq_col_d = seq_col_q + 1'b1;
            end
            S_IDLE: begin
                if (clear_req) begin
                    seq_row_d = '0;
                    seq_col_d = '0;
                end else if (wr_en) begin
                    mem_we    = wr_ok;
                    mem_row   = map_row(wr_row, offset_q);
                    mem_col   = wr_col;
                    mem_wdata = wr_char;
                end else if (put_en) begin
                    mem_we    = !(put_nl || put_cr);
                    mem_row   = map_row(cur_row_q, offset_q);
                    mem_col   = cur_col_q;
                    mem_wdata = put_char;
                    if (put_wraps || put_cr) cur_col_d = '0;
                    else                     cur_col_d = cur_col_q + 1'b1;
                    if (put_wraps && !cur_last_row) cur_row_d = cur_row_q + 1'b1;
                    if (put_scroll) begin
                        // The old top physical row becomes the new bottom row and is blanked.
                        offset_d  = (offset_q == ROW_W'(ROWS-1)) ? '0 : offset_q + 1'b1;
                        seq_row_d = offset_q;
                        seq_col_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
            offset_q  <= '0;
            seq_row_q <= '0;
            seq_col_q <= '0;
            rd_char_q <= '0;
        end else begin
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            offset_q  <= offset_d;
            seq_row_q <= seq_row_d;
            seq_col_q <= seq_col_d;
            rd_char_q <= rd_char_d;
        end
    end

    // Read uses the pre-edge array contents, so a same-cycle write returns old data.
    always_comb begin
        rd_char_d = BLANK_CHAR;
        if (rd_ok) rd_char_d = mem_q[map_row(rd_row, offset_q)][rd_col];
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_row][mem_col] <= mem_wdata;
    end

    assign rd_char    = rd_char_q;
    assign cursor_row = cur_row_q;
    assign cursor_col = cur_col_q;

endmodule

// File: tb/tb_char_plane_scroll.sv
// Randomized bench for char_plane_scroll against a logical-screen model (scroll = shift rows up).
module tb_char_plane_scroll;
    localparam int ROWS = 16;
    localparam int COLS = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rd_row = '0;
    logic [4:0] rd_col = '0;
    logic [7:0] rd_char;
    logic       wr_en = 1'b0;
    logic [3:0] wr_row = '0;
    logic [4:0] wr_col = '0;
    logic [7:0] wr_char = '0;
    logic       put_en = 1'b0;
    logic [7:0] put_char = '0;
    logic       clear_req = 1'b0;
    logic       busy;
    logic [3:0] cursor_row;
    logic [4:0] cursor_col;

    always #5 clk = ~clk;

    char_plane_scroll dut (
        .clk(clk), .rst_n(rst_n),
        .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
        .put_en(put_en), .put_char(put_char), .clear_req(clear_req),
        .busy(busy), .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    int checks = 0;
    int failures = 0;

    // Model: the screen as the viewer sees it, plus cursor and remaining busy cycles.
    logic [7:0] scr [ROWS][COLS];
    int  cur_r, cur_c, busy_cnt;
    bit  home_pend, exp_vld;
    int  exp_rd;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic blank_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    endtask

    task automatic scroll_up();
        for (int r = 0; r < ROWS-1; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
        busy_cnt = COLS;
    endtask

    task automatic new_line();
        cur_c = 0;
        if (cur_r < ROWS-1) cur_r++;
        else scroll_up();
    endtask

    task automatic model_step();
        exp_vld = 1'b0;
        if (busy_cnt == 0) begin
            exp_vld = 1'b1;
            exp_rd  = (int'(rd_row) < ROWS && int'(rd_col) < COLS) ? int'(scr[rd_row][rd_col]) : 8'h20;
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0 && home_pend) begin
                cur_r = 0; cur_c = 0; home_pend = 1'b0;
            end
        end else if (clear_req) begin
            blank_all();
            busy_cnt  = ROWS*COLS;
            home_pend = 1'b1;
        end else if (wr_en) begin
            if (int'(wr_row) < ROWS && int'(wr_col) < COLS) scr[wr_row][wr_col] = wr_char;
        end else if (put_en) begin
`ifdef CHAR_PLANE_NEWLINE_EN
            if (put_char == 8'h0A) new_line();
            else if (put_char == 8'h0D) cur_c = 0;
            else
`endif
            begin
                scr[cur_r][cur_c] = put_char;
                if (cur_c < COLS-1) cur_c++;
                else new_line();
            end
        end
    endtask

    // One clock: model consumes the inputs now driven, then outputs are compared after the edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        chk("busy", int'(busy), (busy_cnt > 0) ? 1 : 0);
        chk("cursor_row", int'(cursor_row), cur_r);
        chk("cursor_col", int'(cursor_col), cur_c);
        if (exp_vld) chk("rd_char", int'(rd_char), exp_rd);
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin n++; tick(); end
    endtask

    task automatic read_at(input int r, input int c);
        rd_row = 4'(r); rd_col = 5'(c);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        blank_all();
        cur_r = 0; cur_c = 0; home_pend = 1'b0; exp_vld = 1'b0; exp_rd = 0;
        busy_cnt = ROWS*COLS;
        repeat (3) @(negedge clk);
        chk("reset_rd_char", int'(rd_char), 0);
        chk("reset_busy", int'(busy), 1);
        chk("reset_cursor_row", int'(cursor_row), 0);
        chk("reset_cursor_col", int'(cursor_col), 0);
        rst_n = 1'b1;
        wait_busy(n);
        chk("reset_clear_cycles", n, 512);
        read_at(5, 7);
        chk("rd_after_clear", int'(rd_char), 8'h20);

        wr_en = 1'b1; wr_row = 4'd3; wr_col = 5'd10; wr_char = 8'h41;
        read_at(3, 10);
        chk("rd_same_cycle_old", int'(rd_char), 8'h20);
        wr_en = 1'b0;
        read_at(3, 10);
        chk("rd_after_write", int'(rd_char), 8'h41);

        put_en = 1'b1;
        for (int i = 0; i < 32; i++) begin put_char = 8'(8'h30 + i); tick(); end
        put_en = 1'b0;
        chk("puts32_row", int'(cursor_row), 1);
        chk("puts32_col", int'(cursor_col), 0);
        read_at(0, 31);
        chk("puts32_last", int'(rd_char), 8'h4F);

        clear_req = 1'b1; wr_en = 1'b1; wr_row = 4'd2; wr_col = 5'd2; wr_char = 8'h55;
        tick();
        clear_req = 1'b0; wr_en = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            put_en = (n == 1); put_char = 8'h77;
            tick();
        end
        put_en = 1'b0;
        chk("clear_cycles", n, 512);
        chk("clear_cursor_row", int'(cursor_row), 0);
        chk("clear_cursor_col", int'(cursor_col), 0);
        read_at(2, 2);
        chk("clear_dropped_write", int'(rd_char), 8'h20);
        read_at(0, 0);
        chk("busy_put_ignored", int'(rd_char), 8'h20);

        put_en = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin put_char = 8'(8'h10 + r); tick(); end
        put_en = 1'b0;
        wait_busy(n);
        chk("scroll_cycles", n, 32);
        chk("scroll_cursor_row", int'(cursor_row), 15);
        chk("scroll_cursor_col", int'(cursor_col), 0);
        read_at(0, 0);
        chk("scroll_top", int'(rd_char), 8'h11);
        read_at(14, 3);
        chk("scroll_row14", int'(rd_char), 8'h1F);
        read_at(15, 9);
        chk("scroll_bottom_blank", int'(rd_char), 8'h20);

        for (int i = 0; i < 4000; i++) begin
            int k;
            k = int'($urandom_range(999));
            clear_req = (k < 2);
            wr_en     = (k >= 2 && k < 250) || (k < 2 && $urandom_range(1) == 1);
            put_en    = (k >= 200);
            wr_row    = 4'($urandom_range(ROWS-1));
            wr_col    = 5'($urandom_range(COLS-1));
            wr_char   = 8'($urandom);
            put_char  = ($urandom_range(15) == 0) ? (($urandom_range(1) == 1) ? 8'h0A : 8'h0D) : 8'($urandom);
            rd_row    = 4'($urandom_range(ROWS-1));
            rd_col    = 5'($urandom_range(COLS-1));
            tick();
        end
        clear_req = 1'b0; wr_en = 1'b0; put_en = 1'b0;
        wait_busy(n);

`ifdef CHAR_PLANE_NEWLINE_EN
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        wait_busy(n);
        put_en = 1'b1;
        put_char = 8'h41; tick();
        put_char = 8'h0A; tick();
        put_en = 1'b0;
        chk("nl_cursor_row", int'(cursor_row), 1);
        chk("nl_cursor_col", int'(cursor_col), 0);
        read_at(0, 1);
        chk("nl_not_stored", int'(rd_char), 8'h20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
